// File: rtl/apb_reg_completer.sv
`default_nettype none
// ============================================================================
// apb_reg_completer : APB completer with a 32-bit register bank, a read-only
// transfer counter and fixed wait states. APB_PSTRB_EN adds byte strobes.
// Revision: 1.0
// ============================================================================
module apb_reg_completer #(
  parameter int          ADDR_W      = 8,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         PSELx,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic [31:0]                  PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [3:0]                   PSTRB,
`endif
  output logic [31:0]                  PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [32*(NUM_REGS-1)-1:0]   reg_out
);

  localparam int         c_CNT_IDX = NUM_REGS - 1;
  localparam logic [3:0] c_WAIT    = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_wait_cnt, w_wait_nxt;
  logic [31:0] r_regs [NUM_REGS-1];
  logic [31:0] r_xfer_cnt;

  logic        w_access, w_setup, w_ready, w_no_setup;
  logic        w_dec_err, w_done;
  logic [31:0] w_idx_ext;
  logic [31:0] w_rd_mux;
  logic [3:0]  w_strb;
  logic        w_strb_err;

  assign w_access  = PSELx & PENABLE;
  assign w_setup   = PSELx & ~PENABLE;
  assign w_idx_ext = 32'(PADDR[ADDR_W-1:2]);

`ifdef APB_PSTRB_EN
  assign w_strb     = PSTRB;
  assign w_strb_err = ~PWRITE & (PSTRB != 4'h0);
`else
  assign w_strb     = 4'hF;
  assign w_strb_err = 1'b0;
`endif

  assign w_dec_err = (PADDR[1:0] != 2'b00)
                   | (w_idx_ext >= 32'(NUM_REGS))
                   | (PWRITE & (w_idx_ext == 32'(c_CNT_IDX)))
                   | w_strb_err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_ready     = 1'b0;
    w_no_setup  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_setup) begin
          w_wait_nxt  = c_WAIT;
          w_state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_READY;
        end else if (w_access) begin
          // Access phase without a preceding setup: reject, stay idle
          w_no_setup = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!PSELx) begin
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = 4'd0;
        end else begin
          w_wait_nxt = r_wait_cnt - 4'd1;
          if (r_wait_cnt <= 4'd1) w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_ready     = w_access;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_done  = w_ready & ~w_dec_err;
  assign PREADY  = w_ready | w_no_setup;
  assign PSLVERR = w_no_setup | (w_ready & w_dec_err);

  // Counter is the default; an RW index overrides it, illegal indices are gated off by w_done
  always_comb begin
    w_rd_mux = r_xfer_cnt;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (w_idx_ext == 32'(i)) w_rd_mux = r_regs[i];
    end
  end

  assign PRDATA = (w_done & ~PWRITE) ? w_rd_mux : 32'h0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS - 1; i++) r_regs[i] <= RESET_VAL;
    end else if (w_done && PWRITE) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (w_idx_ext == 32'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) r_regs[i][8*b +: 8] <= PWDATA[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_xfer_cnt <= 32'h0;
    else if (w_done) r_xfer_cnt <= r_xfer_cnt + 32'd1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS - 1; gi++) begin : g_reg_out
      assign reg_out[32*gi +: 32] = r_regs[gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_completer.sv
`default_nettype none
// ============================================================================
// tb_apb_reg_completer : randomized and directed bench with a register model.
// Revision: 1.0
// ============================================================================
module tb_apb_reg_completer;

  localparam int          ADDR_W      = 8;
  localparam int          NUM_REGS    = 8;
  localparam int          WAIT_CYCLES = 2;
  localparam logic [31:0] RESET_VAL   = 32'hC0DE_0001;

  logic        PCLK = 1'b0;
  logic        PRESETn, PSELx, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [32*(NUM_REGS-1)-1:0] reg_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [NUM_REGS-1];
  logic [31:0] m_cnt;

  apb_reg_completer #(
    .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .WAIT_CYCLES(WAIT_CYCLES), .RESET_VAL(RESET_VAL)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .reg_out(reg_out)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < NUM_REGS - 1; i++) m_regs[i] = RESET_VAL;
    m_cnt = 32'h0;
  endfunction

  task automatic check_regs(input string tag);
    logic mism = 1'b0;
    int   first = -1;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (reg_out[32*i +: 32] !== m_regs[i]) begin
        mism = 1'b1;
        if (first < 0) first = i;
      end
    end
    total++;
    if (mism) begin
      bad++;
      $display("FAIL %s reg_out: reg %0d got %h want %h", tag, first,
               reg_out[32*first +: 32], m_regs[first]);
    end
  endtask

  // One complete APB transfer; expectations come from the address map rules
  task automatic xfer(input logic [7:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [3:0] strb);
    int          idx;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          waits;
    logic        got;
    idx     = int'(addr[7:2]);
    exp_err = (addr[1:0] != 2'b00) || (idx >= NUM_REGS) ||
              (wr && idx == NUM_REGS - 1);
`ifdef APB_PSTRB_EN
    if (!wr && strb != 4'h0) exp_err = 1'b1;
`endif
    exp_rd = 32'h0;
    if (!exp_err && !wr) exp_rd = (idx == NUM_REGS - 1) ? m_cnt : m_regs[idx];

    PSELx = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr;
    PWDATA = wdata; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0; got = 1'b0;
    while (waits <= 20) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) begin
        got = 1'b1;
        break;
      end
      waits++;
    end
    total++;
    if (!got || waits != WAIT_CYCLES) begin
      bad++;
      $display("FAIL latency addr=%h: waits got %0d want %0d (ready seen %0b)",
               addr, waits, WAIT_CYCLES, got);
    end
    if (got) begin
      total++;
      if (PSLVERR !== exp_err) begin
        bad++;
        $display("FAIL pslverr addr=%h wr=%0b: got %b want %b", addr, wr, PSLVERR, exp_err);
      end
      total++;
      if (PRDATA !== exp_rd) begin
        bad++;
        $display("FAIL prdata addr=%h wr=%0b: got %h want %h", addr, wr, PRDATA, exp_rd);
      end
    end
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
    if (!exp_err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) m_regs[idx][8*b +: 8] = wdata[8*b +: 8];
      end
      m_cnt = m_cnt + 32'd1;
    end
    check_regs("after_xfer");
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h0; PWDATA = 32'h0; PSTRB = 4'h0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    total++;
    if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
      bad++;
      $display("FAIL reset outputs: got rdy=%b err=%b rd=%h want 0 0 0", PREADY, PSLVERR, PRDATA);
    end
    check_regs("reset");
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
  endtask

  task automatic test_basic();
    xfer(8'h04, 1'b1, 32'hDEADBEEF, 4'hF);
    xfer(8'h04, 1'b0, 32'h0, 4'h0);
    total++;
    if (reg_out[63:32] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic reg1: got %h want deadbeef", reg_out[63:32]);
    end
    xfer(8'h1C, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_back_to_back();
    xfer(8'h00, 1'b1, 32'h1234_5678, 4'hF);
    xfer(8'h08, 1'b1, 32'h9ABC_DEF0, 4'hF);
    xfer(8'h00, 1'b0, 32'h0, 4'h0);
    xfer(8'h08, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_errors();
    xfer(8'h05, 1'b1, 32'hFFFF_FFFF, 4'hF);
    xfer(8'h24, 1'b0, 32'h0, 4'h0);
    xfer(8'h1C, 1'b1, 32'h0000_0055, 4'hF);
    xfer(8'h1C, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_no_setup();
    PSELx = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h0C;
    PWDATA = 32'h5555_AAAA; PSTRB = 4'hF;
    @(negedge PCLK);
    total++;
    if (PREADY !== 1'b1 || PSLVERR !== 1'b1 || PRDATA !== 32'h0) begin
      bad++;
      $display("FAIL no_setup: got rdy=%b err=%b rd=%h want 1 1 0", PREADY, PSLVERR, PRDATA);
    end
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
    check_regs("no_setup");
    xfer(8'h1C, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_abort();
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C;
    PWDATA = 32'hBAD0_0BAD; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    total++;
    if (PREADY !== 1'b0) begin
      bad++;
      $display("FAIL abort wait1 pready: got %b want 0", PREADY);
    end
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    total++;
    if (PREADY !== 1'b0) begin
      bad++;
      $display("FAIL abort drop pready: got %b want 0", PREADY);
    end
    @(posedge PCLK); #1;
    check_regs("abort");
    xfer(8'h0C, 1'b0, 32'h0, 4'h0);
    xfer(8'h1C, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_reset_mid();
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10;
    PWDATA = 32'h0F0F_F0F0; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0;
    model_reset();
    #1;
    total++;
    if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid outputs: got rdy=%b err=%b rd=%h want 0 0 0", PREADY, PSLVERR, PRDATA);
    end
    check_regs("reset_mid");
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(8'h10, 1'b1, 32'h0F0F_F0F0, 4'hF);
    xfer(8'h10, 1'b0, 32'h0, 4'h0);
    xfer(8'h1C, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  a;
      logic        w;
      logic [3:0]  s;
      a = {2'b00, 6'($urandom_range(0, 9)), 2'b00};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      w = 1'($urandom_range(0, 1));
      s = w ? 4'hF : 4'h0;
`ifdef APB_PSTRB_EN
      if (w) s = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 5) == 0) s = 4'($urandom_range(1, 15));
`endif
      xfer(a, w, $urandom, s);
    end
  endtask

`ifdef APB_PSTRB_EN
  task automatic test_strobe();
    xfer(8'h08, 1'b1, 32'h1122_3344, 4'hF);
    xfer(8'h08, 1'b1, 32'hAABB_CCDD, 4'b0101);
    total++;
    if (reg_out[95:64] !== 32'h11BB_33DD) begin
      bad++;
      $display("FAIL strobe reg2: got %h want 11bb33dd", reg_out[95:64]);
    end
    xfer(8'h08, 1'b0, 32'h0, 4'b0001);
    xfer(8'h08, 1'b1, 32'hFFFF_FFFF, 4'h0);
    xfer(8'h1C, 1'b0, 32'h0, 4'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_no_setup();
    test_abort();
    test_reset_mid();
`ifdef APB_PSTRB_EN
    test_strobe();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_reg_completer.md
Name: apb_reg_completer

Overview:
- APB completer holding a small bank of 32-bit control registers. It sits directly downstream of the APB requester FSM and consumes its PSELx/PENABLE phases together with PADDR/PWRITE/PWDATA.
- Returns PREADY, PRDATA and PSLVERR.
- Inserts a fixed, programmable number of wait states so the requester's ACCESS-hold path is exercised.
- Exposes register contents to downstream logic on a flat vector.

Parameters:
ADDR_W, 8, width of PADDR; word index = PADDR[ADDR_W-1:2]
NUM_REGS, 8, total registers; indices 0..NUM_REGS-2 RW, index NUM_REGS-1 RO transfer counter (legal range 2..2^(ADDR_W-2))
WAIT_CYCLES, 2, wait states inserted in every access phase (legal range 0..15)
RESET_VAL, 32'h0, reset value of every RW register

Ports:
PCLK  in  1  clock, rising edge
PRESETn  in  1  asynchronous, active-low reset
PSELx  in  1  completer selected
PENABLE  in  1  access phase indicator
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_W  byte address
PWDATA  in  32  write data
PRDATA  out  32  read data, valid only when PREADY=1
PREADY  out  1  transfer completes this cycle
PSLVERR  out  1  error response, valid only when PREADY=1
reg_out  out  32*(NUM_REGS-1)  RW register contents; reg i at bits [32*i+31:32*i]

Behaviour:
- One clock, PCLK; reset PRESETn is asynchronous, active-low.
- Reset values:
  - state = IDLE; wait counter = 0.
  - All RW regs = RESET_VAL; transfer counter = 0.
  - PREADY = 0, PSLVERR = 0, PRDATA = 0.
- States: IDLE, WAIT, READY.
- IDLE:
  - PSELx=1 and PENABLE=0 (setup) loads wait counter = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else READY.
  - PSELx=1 and PENABLE=1 in IDLE (no setup seen): PREADY=1, PSLVERR=1, no register effect, stay IDLE.
- WAIT:
  - Counter decrements each cycle; PREADY=0.
  - When counter reaches 1, next state is READY.
  - PSELx dropping in WAIT returns to IDLE with no write and no count.
- READY:
  - PREADY = PSELx & PENABLE; completion occurs on this edge; next state is IDLE.
  - If PSELx=0, return to IDLE silently.
- Latency: access phase lasts exactly WAIT_CYCLES+1 cycles. WAIT_CYCLES=0 gives a zero-wait completer.
- Error decode (PSLVERR=1 in the completion cycle) on any of:
  - PADDR[1:0] != 0;
  - index >= NUM_REGS;
  - write to index NUM_REGS-1 (RO counter).
  An errored transfer modifies no register and does not increment the counter.
- Write: RW reg[index] <= PWDATA on the completion edge. New value is visible on reg_out the following cycle.
- Read:
  - PRDATA = reg[index] combinationally during the completion cycle; 0 otherwise and 0 on error.
  - Reading the counter returns its value before the current transfer's increment.
- Transfer counter: +1 per completed non-error transfer (read or write); wraps 32'hFFFF_FFFF -> 0.
- PADDR/PWRITE/PWDATA are sampled in the completion cycle. The requester holds them stable through ACCESS per APB.
- Back-to-back transfers: the setup cycle immediately following completion is accepted from IDLE with no bubble.
- Reset asserted mid-transfer: immediate return to reset values; no partial write.

Optional Feature:
APB_PSTRB_EN
- Defined:
  - Adds input PSTRB [3:0].
  - Write updates byte k only if PSTRB[k]=1.
  - PSTRB=0 write completes, no error, no change, counter increments.
  - A read with PSTRB != 0 returns PSLVERR=1.
- Undefined: no PSTRB port; every write updates all 32 bits.

Test Plan:
- WAIT_CYCLES=2: write 0xDEADBEEF to 0x04, then read 0x04 -> PREADY low 2 access cycles then high; PRDATA=0xDEADBEEF; reg_out[63:32]=0xDEADBEEF; read of 0x1C returns 2.
- WAIT_CYCLES=0: back-to-back writes to 0x00, 0x08 -> each access phase is 1 cycle; PREADY high on first ENABLE cycle; both regs updated.
- Address errors:
  - write 0x05 -> PSLVERR=1, no reg change;
  - read 0x24 -> PSLVERR=1, PRDATA=0;
  - write 0x55 to 0x1C -> PSLVERR=1, counter unchanged.
- PSELx drops after 1 WAIT cycle of a write to 0x0C -> no PREADY, reg 3 unchanged, counter unchanged.
- Reset mid-transfer: assert PRESETn=0 during WAIT of a write to 0x10 -> all outputs/regs return to reset values asynchronously; next transfer works normally.
- With APB_PSTRB_EN: reg 2 = 0x11223344, write 0xAABBCCDD with PSTRB=4'b0101 -> reg 2 = 0x11BB33DD; read with PSTRB=4'b0001 -> PSLVERR=1.
